// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller sitting behind the core's data-memory port.
// It accepts one request at a time over a valid/yumi handshake and holds a
// word-organised SRAM with byte-lane writes. The response appears a fixed
// latency_p cycles after the accept cycle and is held until the core yumis it.
//
// Optional build macro DMEM_ALIGN_CHECK_EN adds rsp_err_o. Misaligned word
// accesses and out-of-range addresses are then flagged, return zero data and
// do not write the array. Without the macro, the address is wrapped onto the
// array and the low two bits of word accesses are ignored.
//
// Assumes addr_width_p + 2 < 32 and 1 <= latency_p <= 15.
`timescale 1ns/1ps
module dmem_ctrl #(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    input  logic        req_wen_i,
    input  logic        req_byte_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_yumi_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    input  logic        rsp_yumi_i,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic        rsp_err_o,
`endif
    output logic        busy_o
);

    localparam int         DEPTH  = 1 << addr_width_p;
    localparam logic [3:0] LAT_M1 = 4'(latency_p - 1);

    if (latency_p < 1 || latency_p > 15) begin : g_bad_latency
        $error("dmem_ctrl: latency_p must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_count;
    logic [3:0]              w_next_count;
    logic [31:0]             r_rdata;
    logic [31:0]             r_mem [0:DEPTH-1];

    logic                    w_accept;
    logic                    w_rsp_valid;
    logic                    w_err;
    logic                    w_store_en;
    logic [addr_width_p-1:0] w_idx;
    logic [1:0]              w_lane;
    logic [31:0]             w_word;
    logic [7:0]              w_byte;
    logic [31:0]             w_load_data;

    // Address decode and the read path for a load accepted this cycle.
    assign w_idx  = req_addr_i[addr_width_p+1:2];
    assign w_lane = req_addr_i[1:0];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_err;

    // Misaligned word access, or any address bit above the array's reach.
    assign w_err = (!req_byte_i && (w_lane != 2'b00)) ||
                   (|req_addr_i[31:addr_width_p+2]);

    // The error flag is only meaningful alongside a valid response.
    assign rsp_err_o = r_err && w_rsp_valid;
`else
    // High address bits simply alias onto the array in this build.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = |req_addr_i[31:addr_width_p+2];
    assign w_err            = 1'b0;
`endif

    assign w_store_en  = w_accept && req_wen_i && !w_err;
    assign w_load_data = w_err      ? 32'd0 :
                         req_byte_i ? {24'd0, w_byte} : w_word;

    // Next-state, counter and handshake logic for the request FSM.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_accept     = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Reset dominates: nothing is accepted while it is asserted.
                w_accept = req_valid_i && !reset;
                if (w_accept) begin
                    w_next_state = S_BUSY;
                    w_next_count = LAT_M1;
                end
            end
            S_BUSY: begin
                if (r_count == 4'd0) begin
                    // Final latency cycle: the response is already presented,
                    // so a yumi here completes the transaction immediately.
                    w_rsp_valid  = 1'b1;
                    w_next_state = rsp_yumi_i ? S_IDLE : S_RESP;
                end else begin
                    w_next_count = r_count - 4'd1;
                end
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (rsp_yumi_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign req_yumi_o  = w_accept;
    assign rsp_valid_o = w_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign busy_o      = (r_state != S_IDLE);

    // State, latency counter and read-data holding register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            // Stores leave the previous read data in place; error accesses
            // return zero whatever their direction.
            if (w_accept && (!req_wen_i || w_err)) begin
                r_rdata <= w_load_data;
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Error flag captured at accept, cleared whenever the FSM returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_err;
        end else if (w_next_state == S_IDLE) begin
            r_err <= 1'b0;
        end
    end
`endif

    // SRAM array with byte-lane writes on the accept edge.
    // NOTE: the array has no reset; its contents survive reset by design and a
    // reset branch would prevent mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (w_store_en) begin
            if (req_byte_i) begin
                r_mem[w_idx][{w_lane, 3'b000} +: 8] <= req_wdata_i[7:0];
            end else begin
                r_mem[w_idx] <= req_wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl. Two instances share the stimulus bus: u_lat2
// (latency_p = 2) and u_lat1 (latency_p = 1); use_l1 selects which one sees
// the handshake inputs and which one is observed.
`timescale 1ns/1ps
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_wen;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_yumi;
    logic        use_l1;

    logic        a_yumi, a_valid, a_busy;
    logic [31:0] a_rdata;
    logic        b_yumi, b_valid, b_busy;
    logic [31:0] b_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

`ifdef DMEM_ALIGN_CHECK_EN
    logic a_err, b_err;
`endif

    dmem_ctrl #(.addr_width_p(10), .latency_p(2)) u_lat2 (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid & ~use_l1),
        .req_wen_i   (req_wen),
        .req_byte_i  (req_byte),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_yumi_o  (a_yumi),
        .rsp_valid_o (a_valid),
        .rsp_rdata_o (a_rdata),
        .rsp_yumi_i  (rsp_yumi & ~use_l1),
`ifdef DMEM_ALIGN_CHECK_EN
        .rsp_err_o   (a_err),
`endif
        .busy_o      (a_busy)
    );

    dmem_ctrl #(.addr_width_p(10), .latency_p(1)) u_lat1 (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid & use_l1),
        .req_wen_i   (req_wen),
        .req_byte_i  (req_byte),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_yumi_o  (b_yumi),
        .rsp_valid_o (b_valid),
        .rsp_rdata_o (b_rdata),
        .rsp_yumi_i  (rsp_yumi & use_l1),
`ifdef DMEM_ALIGN_CHECK_EN
        .rsp_err_o   (b_err),
`endif
        .busy_o      (b_busy)
    );

    wire        yumi      = use_l1 ? b_yumi  : a_yumi;
    wire        rsp_valid = use_l1 ? b_valid : a_valid;
    wire [31:0] rsp_rdata = use_l1 ? b_rdata : a_rdata;
    wire        busy      = use_l1 ? b_busy  : a_busy;
`ifdef DMEM_ALIGN_CHECK_EN
    wire        rsp_err   = use_l1 ? b_err   : a_err;
`else
    wire        rsp_err   = 1'b0;
`endif

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: present the request, report whether it was
    // accepted, the cycle (counted from the accept edge) at which rsp_valid
    // first rose, the response data/error, then consume the response.
    task automatic do_txn(input logic wen, input logic bt, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic acc, output int lat,
                          output logic [31:0] rdata, output logic err);
        req_valid = 1'b1;
        req_wen   = wen;
        req_byte  = bt;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        acc = yumi;
        tick();
        req_valid = 1'b0;
        #1;
        lat   = -1;
        rdata = 32'd0;
        err   = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (rsp_valid) begin
                lat   = c;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
            tick();
            #1;
        end
        if (lat > 0) begin
            rsp_yumi = 1'b1;
            tick();
            rsp_yumi = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        for (int s = 0; s < 2; s++) begin
            use_l1 = (s == 1);
            #1;
            n_checks++;
            if (yumi !== 1'b0) begin n_errors++; $display("FAIL reset_yumi dut%0d got %b exp 0", s, yumi); end
            n_checks++;
            if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid dut%0d got %b exp 0", s, rsp_valid); end
            n_checks++;
            if (rsp_rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rdata dut%0d got %h exp 0", s, rsp_rdata); end
            n_checks++;
            if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy dut%0d got %b exp 0", s, busy); end
        end
        use_l1 = 1'b0;
        reset  = 1'b0;
        tick();
    endtask

    task automatic test_word();
        logic acc, err;
        int lat;
        logic [31:0] rd;
        use_l1 = 1'b0;
        do_txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, acc, lat, rd, err);
        n_checks++;
        if (acc !== 1'b1) begin n_errors++; $display("FAIL word_store_yumi got %b exp 1", acc); end
        n_checks++;
        if (lat != 2) begin n_errors++; $display("FAIL word_store_latency got %0d exp 2", lat); end
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL word_store_rdata_held got %h exp 0", rd); end
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (lat != 2) begin n_errors++; $display("FAIL word_load_latency got %0d exp 2", lat); end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL word_load_data got %h exp deadbeef", rd); end
    endtask

    task automatic test_byte();
        logic acc, err;
        int lat;
        logic [31:0] rd;
        use_l1 = 1'b0;
        do_txn(1'b1, 1'b0, 32'h10, 32'h11223344, acc, lat, rd, err);
        do_txn(1'b1, 1'b1, 32'h11, 32'hFFFFFFAA, acc, lat, rd, err);
        n_checks++;
        if (lat != 2) begin n_errors++; $display("FAIL byte_store_latency got %0d exp 2", lat); end
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (rd !== 32'h1122AA44) begin n_errors++; $display("FAIL byte_merge_word got %h exp 1122aa44", rd); end
        do_txn(1'b0, 1'b1, 32'h13, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (rd !== 32'h00000011) begin n_errors++; $display("FAIL byte_load_lane3 got %h exp 00000011", rd); end
        do_txn(1'b0, 1'b1, 32'h10, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (rd !== 32'h00000044) begin n_errors++; $display("FAIL byte_load_lane0 got %h exp 00000044", rd); end
        do_txn(1'b1, 1'b1, 32'h70, 32'h77, acc, lat, rd, err);
        n_checks++;
        if (rd !== 32'h00000044) begin n_errors++; $display("FAIL store_rsp_holds_rdata got %h exp 00000044", rd); end
    endtask

    task automatic test_hold();
        logic acc, err;
        int lat;
        logic [31:0] rd;
        logic stray;
        use_l1    = 1'b0;
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        #1;
        n_checks++;
        if (yumi !== 1'b1) begin n_errors++; $display("FAIL hold_first_yumi got %b exp 1", yumi); end
        tick();
        // Second request held valid from the cycle after the first accept.
        req_wen   = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h0BADCAFE;
        #1;
        lat   = -1;
        stray = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (yumi) stray = 1'b1;
            if (rsp_valid) begin lat = c; break; end
            tick();
            #1;
        end
        n_checks++;
        if (lat != 2) begin n_errors++; $display("FAIL hold_latency got %0d exp 2", lat); end
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1122AA44) stray = 1'b1;
            if (yumi) stray = 1'b1;
            tick();
            #1;
        end
        n_checks++;
        if (stray !== 1'b0) begin n_errors++; $display("FAIL hold_stable got unstable/accepted exp stable"); end
        rsp_yumi = 1'b1;
        #1;
        n_checks++;
        if (yumi !== 1'b0) begin n_errors++; $display("FAIL hold_no_same_cycle_accept got %b exp 0", yumi); end
        tick();
        rsp_yumi = 1'b0;
        #1;
        n_checks++;
        if (yumi !== 1'b1) begin n_errors++; $display("FAIL hold_accept_next_idle got %b exp 1", yumi); end
        tick();
        req_valid = 1'b0;
        #1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (rsp_valid) begin lat = c; break; end
            tick();
            #1;
        end
        n_checks++;
        if (lat != 2) begin n_errors++; $display("FAIL hold_second_latency got %0d exp 2", lat); end
        rsp_yumi = 1'b1;
        tick();
        rsp_yumi = 1'b0;
        do_txn(1'b0, 1'b0, 32'h20, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (rd !== 32'h0BADCAFE) begin n_errors++; $display("FAIL hold_second_store_data got %h exp 0badcafe", rd); end
    endtask

    task automatic test_back_to_back();
        logic acc, err;
        int lat;
        logic [31:0] rd;
        use_l1 = 1'b1;
        do_txn(1'b1, 1'b0, 32'h40, 32'h01020304, acc, lat, rd, err);
        n_checks++;
        if (lat != 1) begin n_errors++; $display("FAIL b2b_setup_latency got %0d exp 1", lat); end
        do_txn(1'b0, 1'b0, 32'h40, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (acc !== 1'b1 || lat != 1) begin n_errors++; $display("FAIL b2b_load1_timing got acc=%b lat=%0d exp acc=1 lat=1", acc, lat); end
        n_checks++;
        if (rd !== 32'h01020304) begin n_errors++; $display("FAIL b2b_load1_data got %h exp 01020304", rd); end
        do_txn(1'b1, 1'b0, 32'h40, 32'hCAFEF00D, acc, lat, rd, err);
        n_checks++;
        if (acc !== 1'b1 || lat != 1) begin n_errors++; $display("FAIL b2b_store_timing got acc=%b lat=%0d exp acc=1 lat=1", acc, lat); end
        do_txn(1'b0, 1'b0, 32'h40, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (acc !== 1'b1 || lat != 1) begin n_errors++; $display("FAIL b2b_load2_timing got acc=%b lat=%0d exp acc=1 lat=1", acc, lat); end
        n_checks++;
        if (rd !== 32'hCAFEF00D) begin n_errors++; $display("FAIL b2b_load2_data got %h exp cafef00d", rd); end
        use_l1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic acc, err;
        int lat;
        logic [31:0] rd;
        logic rose;
        use_l1 = 1'b0;
        do_txn(1'b1, 1'b0, 32'h30, 32'h5555AAAA, acc, lat, rd, err);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'h30;
        #1;
        tick();
        req_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_in_busy got %b exp 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_idle got busy=%b valid=%b exp 0 0", busy, rsp_valid); end
        n_checks++;
        if (rsp_rdata !== 32'd0) begin n_errors++; $display("FAIL rstmid_rdata got %h exp 0", rsp_rdata); end
        rose = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid) rose = 1'b1;
            tick();
            #1;
        end
        n_checks++;
        if (rose !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_response got 1 exp 0"); end
        do_txn(1'b0, 1'b0, 32'h30, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (rd !== 32'h5555AAAA || lat != 2) begin n_errors++; $display("FAIL rstmid_data_kept got %h lat=%0d exp 5555aaaa lat=2", rd, lat); end
    endtask

`ifdef DMEM_ALIGN_CHECK_EN
    task automatic test_align_check();
        logic acc, err;
        int lat;
        logic [31:0] rd;
        use_l1 = 1'b0;
        do_txn(1'b1, 1'b0, 32'h10, 32'h11111111, acc, lat, rd, err);
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL align_ok_store_err got %b exp 0", err); end
        do_txn(1'b1, 1'b0, 32'h12, 32'h99999999, acc, lat, rd, err);
        n_checks++;
        if (err !== 1'b1 || rd !== 32'd0 || lat != 2) begin n_errors++; $display("FAIL align_misaligned_store got err=%b rd=%h lat=%0d exp 1 0 2", err, rd, lat); end
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (err !== 1'b0 || rd !== 32'h11111111) begin n_errors++; $display("FAIL align_mem_unchanged got err=%b rd=%h exp 0 11111111", err, rd); end
        do_txn(1'b0, 1'b0, 32'h10000, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (err !== 1'b1 || rd !== 32'd0) begin n_errors++; $display("FAIL align_out_of_range got err=%b rd=%h exp 1 0", err, rd); end
        do_txn(1'b0, 1'b1, 32'h13, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (err !== 1'b0 || rd !== 32'h00000011) begin n_errors++; $display("FAIL align_byte_ok got err=%b rd=%h exp 0 00000011", err, rd); end
    endtask
`else
    task automatic test_alias_align();
        logic acc, err;
        int lat;
        logic [31:0] rd;
        use_l1 = 1'b0;
        do_txn(1'b1, 1'b0, 32'h52, 32'h12345678, acc, lat, rd, err);
        do_txn(1'b0, 1'b0, 32'h50, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (rd !== 32'h12345678) begin n_errors++; $display("FAIL misaligned_word_ignored got %h exp 12345678", rd); end
        do_txn(1'b0, 1'b0, 32'h1050, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (rd !== 32'h12345678) begin n_errors++; $display("FAIL address_alias got %h exp 12345678", rd); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_yumi  = 1'b0;
        use_l1    = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef DMEM_ALIGN_CHECK_EN
        test_align_check();
`else
        test_alias_align();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
